alarm_time_set: RTL and testbench

- Writer side of the alarm-time registers that the alarm comparator reads. It turns user buttons into a 12-hour BCD alarm setting (hours, minutes, AM/PM) and an alarm-enable flag.
- Outputs feed directly into the alarm comparator's alarm_* inputs and its en input.
- Runs on clk_fast. Buttons are asynchronous levels, synchronised internally.
- Provides edge detection and hold-to-auto-repeat.

---
 rtl/alarm_time_set_pkg.sv | 77 +++++++
 rtl/alarm_time_set_button_repeat.sv | 106 ++++++++++
 rtl/alarm_time_set.sv | 113 +++++++++++
 tb/tb_alarm_time_set.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_time_set_pkg.sv
// Shared types, constants and BCD step helpers for the alarm-time setter.
package alarm_time_set_pkg;

  // One BCD digit
  typedef logic [3:0] bcd_t;

  // Power-up / reset alarm time is 12:00 AM
  localparam bcd_t HOURS_RESET_MSD = 4'd1;
  localparam bcd_t HOURS_RESET_LSD = 4'd2;

  // Largest legal minute digits
  localparam bcd_t MINUTES_MSD_MAX = 4'd5;
  localparam bcd_t MINUTES_LSD_MAX = 4'd9;

  // Width of the per-button hold counter (covers delays up to 65535)
  localparam int HOLD_CNT_W = 16;
  typedef logic [HOLD_CNT_W-1:0] hold_cnt_t;

  // Auto-repeat progress of a held button:
  //   IDLE   - no repeat pending (button released, disabled, or no fresh press)
  //   FIRST  - waiting out the long initial delay after a press
  //   REPEAT - issuing increments at the shorter repeat period
  typedef enum logic [1:0] {
    HOLD_IDLE   = 2'd0,
    HOLD_FIRST  = 2'd1,
    HOLD_REPEAT = 2'd2
  } hold_state_t;

  // Result of one hours increment; toggle_pm is set on the 11 -> 12 step
  typedef struct packed {
    bcd_t msd;
    bcd_t lsd;
    logic toggle_pm;
  } hours_step_t;

  // Result of one minutes increment
  typedef struct packed {
    bcd_t msd;
    bcd_t lsd;
  } minutes_step_t;

  // 12-hour clock face: 12 -> 1 -> ... -> 11 -> 12, never 0
  function automatic hours_step_t next_hours(input bcd_t msd, input bcd_t lsd);
    hours_step_t r;
    r.msd       = msd;
    r.lsd       = lsd + 4'd1;
    r.toggle_pm = 1'b0;
    if (msd == HOURS_RESET_MSD && lsd == HOURS_RESET_LSD) begin
      r.msd = 4'd0;
      r.lsd = 4'd1;
    end else if (msd == 4'd1 && lsd == 4'd1) begin
      r.lsd       = 4'd2;
      r.toggle_pm = 1'b1;
    end else if (lsd == 4'd9) begin
      r.msd = 4'd1;
      r.lsd = 4'd0;
    end
    return r;
  endfunction

  // 00..59 wrapping counter; the wrap deliberately does not carry into hours
  function automatic minutes_step_t next_minutes(input bcd_t msd, input bcd_t lsd);
    minutes_step_t r;
    r.msd = msd;
    r.lsd = lsd + 4'd1;
    if (lsd == MINUTES_LSD_MAX) begin
      r.lsd = 4'd0;
      if (msd == MINUTES_MSD_MAX) begin
        r.msd = 4'd0;
      end else begin
        r.msd = msd + 4'd1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/alarm_time_set_button_repeat.sv
// One user button: 2-flop synchroniser, rising-edge detect and optional
// hold-to-auto-repeat. Produces the synchronised level and a one-cycle inc.
module alarm_time_set_button_repeat #(
  parameter int unsigned REPEAT_DELAY  = 32768,
  parameter int unsigned REPEAT_PERIOD = 8192,
  parameter bit          REPEAT_EN     = 1'b1
) (
  input  logic clk_fast,
  input  logic reset,
  input  logic en,
  input  logic btn,
  output logic level,
  output logic inc
);
  import alarm_time_set_pkg::*;

  // Counter compares against "one less" because the counter is cleared on
  // the edge that applies an increment, so that edge itself is cycle one.
  localparam hold_cnt_t DELAY_LAST  = hold_cnt_t'(REPEAT_DELAY - 1);
  localparam hold_cnt_t PERIOD_LAST = hold_cnt_t'(REPEAT_PERIOD - 1);

  logic        s1;
  logic        s2;
  logic        p;
  hold_cnt_t   cnt;
  logic        cnt_clr;
  logic        cnt_step;
  hold_state_t state;
  hold_state_t state_next;

  assign level = s2;

  // Synchroniser keeps running even when disabled so that a button already
  // held when en rises is seen as old news rather than a fresh edge
  always_ff @(posedge clk_fast or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      p  <= 1'b0;
    end else begin
      s1 <= btn;
      s2 <= s1;
      p  <= s2;
    end
  end

  // Repeat-state register
  always_ff @(posedge clk_fast or posedge reset) begin
    if (reset) begin
      state <= HOLD_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Hold counter: counts cycles since the last increment while armed
  always_ff @(posedge clk_fast or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (cnt_clr) begin
      cnt <= '0;
    end else if (cnt_step) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Edge/repeat decision; repeats only ever follow a genuine enabled press
  always_comb begin
    state_next = state;
    inc        = 1'b0;
    cnt_clr    = 1'b0;
    cnt_step   = 1'b0;
    if (!en || !s2) begin
      state_next = HOLD_IDLE;
      cnt_clr    = 1'b1;
    end else if (!p) begin
      inc        = 1'b1;
      cnt_clr    = 1'b1;
      state_next = REPEAT_EN ? HOLD_FIRST : HOLD_IDLE;
    end else begin
      case (state)
        HOLD_FIRST: begin
          if (cnt == DELAY_LAST) begin
            inc        = 1'b1;
            cnt_clr    = 1'b1;
            state_next = HOLD_REPEAT;
          end else begin
            cnt_step = 1'b1;
          end
        end
        HOLD_REPEAT: begin
          if (cnt == PERIOD_LAST) begin
            inc     = 1'b1;
            cnt_clr = 1'b1;
          end else begin
            cnt_step = 1'b1;
          end
        end
        default: begin
          cnt_clr = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/alarm_time_set.sv
// Alarm-time writer: turns hours/minutes/arm buttons into the 12-hour BCD
// alarm setting and enable flag consumed by the alarm comparator.
module alarm_time_set #(
  parameter int unsigned REPEAT_DELAY  = 32768,
  parameter int unsigned REPEAT_PERIOD = 8192
) (
  input  logic       clk_fast,
  input  logic       reset,
  input  logic       en,
  input  logic       btn_hours,
  input  logic       btn_minutes,
  input  logic       btn_arm,
  output logic       alarm_pm,
  output logic [3:0] alarm_hours_msd,
  output logic [3:0] alarm_hours_lsd,
  output logic [3:0] alarm_minutes_msd,
  output logic [3:0] alarm_minutes_lsd,
  output logic [3:0] alarm_seconds_msd,
  output logic [3:0] alarm_seconds_lsd,
  output logic       alarm_enable,
  output logic       setting_active
);
  import alarm_time_set_pkg::*;

  logic          hours_level;
  logic          hours_inc;
  logic          minutes_level;
  logic          minutes_inc;
  logic          unused_arm_level;
  logic          arm_inc;
  hours_step_t   hours_step;
  minutes_step_t minutes_step;

  // The alarm always fires on the whole minute
  assign alarm_seconds_msd = 4'd0;
  assign alarm_seconds_lsd = 4'd0;

  alarm_time_set_button_repeat #(
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD),
    .REPEAT_EN    (1'b1)
  ) u_hours (
    .clk_fast(clk_fast),
    .reset   (reset),
    .en      (en),
    .btn     (btn_hours),
    .level   (hours_level),
    .inc     (hours_inc)
  );

  alarm_time_set_button_repeat #(
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD),
    .REPEAT_EN    (1'b1)
  ) u_minutes (
    .clk_fast(clk_fast),
    .reset   (reset),
    .en      (en),
    .btn     (btn_minutes),
    .level   (minutes_level),
    .inc     (minutes_inc)
  );

  // Arming is a toggle, so holding the button must never repeat
  alarm_time_set_button_repeat #(
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD),
    .REPEAT_EN    (1'b0)
  ) u_arm (
    .clk_fast(clk_fast),
    .reset   (reset),
    .en      (en),
    .btn     (btn_arm),
    .level   (unused_arm_level),
    .inc     (arm_inc)
  );

  // Candidate next values; only committed when the matching inc fires
  always_comb begin
    hours_step   = next_hours(alarm_hours_msd, alarm_hours_lsd);
    minutes_step = next_minutes(alarm_minutes_msd, alarm_minutes_lsd);
  end

  // Alarm setting registers; hours and minutes update independently
  always_ff @(posedge clk_fast or posedge reset) begin
    if (reset) begin
      alarm_pm          <= 1'b0;
      alarm_hours_msd   <= HOURS_RESET_MSD;
      alarm_hours_lsd   <= HOURS_RESET_LSD;
      alarm_minutes_msd <= 4'd0;
      alarm_minutes_lsd <= 4'd0;
      alarm_enable      <= 1'b0;
      setting_active    <= 1'b0;
    end else begin
      if (hours_inc) begin
        alarm_hours_msd <= hours_step.msd;
        alarm_hours_lsd <= hours_step.lsd;
        if (hours_step.toggle_pm) begin
          alarm_pm <= ~alarm_pm;
        end
      end
      if (minutes_inc) begin
        alarm_minutes_msd <= minutes_step.msd;
        alarm_minutes_lsd <= minutes_step.lsd;
      end
      if (arm_inc) begin
        alarm_enable <= ~alarm_enable;
      end
      setting_active <= hours_level | minutes_level;
    end
  end

endmodule

// File: tb/tb_alarm_time_set.sv
// Scoreboard bench for alarm_time_set with short repeat timing.
// Stimulus pushes hand-computed expected snapshots stamped with the cycle at
// which they must hold; a separate monitor pops and compares them.
//
// Note on reset during a hold: reset clears both the synchroniser and the
// previous-value flop, so a button still held across reset release is seen
// as a brand-new press and increments once after release. This is accepted
// behaviour and is checked explicitly near the end.
module tb_alarm_time_set;

  localparam int DELAY  = 4;
  localparam int PERIOD = 2;

  localparam logic [2:0] B_HOURS   = 3'b001;
  localparam logic [2:0] B_MINUTES = 3'b010;
  localparam logic [2:0] B_ARM     = 3'b100;

  typedef struct packed {
    logic       pm;
    logic [3:0] hm;
    logic [3:0] hl;
    logic [3:0] mm;
    logic [3:0] ml;
    logic [3:0] sm;
    logic [3:0] sl;
    logic       aen;
    logic       sact;
  } snap_t;

  typedef struct {
    int    cyc;
    string name;
    snap_t exp;
  } entry_t;

  logic       clk_fast;
  logic       reset;
  logic       en;
  logic       btn_hours;
  logic       btn_minutes;
  logic       btn_arm;
  logic       alarm_pm;
  logic [3:0] alarm_hours_msd;
  logic [3:0] alarm_hours_lsd;
  logic [3:0] alarm_minutes_msd;
  logic [3:0] alarm_minutes_lsd;
  logic [3:0] alarm_seconds_msd;
  logic [3:0] alarm_seconds_lsd;
  logic       alarm_enable;
  logic       setting_active;

  int     cyc = 0;
  int     vectors = 0;
  int     miscompares = 0;
  entry_t sb_q[$];

  alarm_time_set #(
    .REPEAT_DELAY (DELAY),
    .REPEAT_PERIOD(PERIOD)
  ) dut (
    .clk_fast         (clk_fast),
    .reset            (reset),
    .en               (en),
    .btn_hours        (btn_hours),
    .btn_minutes      (btn_minutes),
    .btn_arm          (btn_arm),
    .alarm_pm         (alarm_pm),
    .alarm_hours_msd  (alarm_hours_msd),
    .alarm_hours_lsd  (alarm_hours_lsd),
    .alarm_minutes_msd(alarm_minutes_msd),
    .alarm_minutes_lsd(alarm_minutes_lsd),
    .alarm_seconds_msd(alarm_seconds_msd),
    .alarm_seconds_lsd(alarm_seconds_lsd),
    .alarm_enable     (alarm_enable),
    .setting_active   (setting_active)
  );

  // Free-running clock
  initial begin
    clk_fast = 1'b0;
    forever #5 clk_fast = ~clk_fast;
  end

  // Cycle stamp used to line expectations up with DUT edges
  always @(posedge clk_fast) begin
    cyc <= cyc + 1;
  end

  // Queue an expected snapshot that must hold 'delta' edges from now
  task automatic push_expect(input int delta, input string name, input logic pm,
                             input int hours, input int minutes, input logic aen,
                             input logic sact);
    entry_t e;
    e.cyc      = cyc + delta;
    e.name     = name;
    e.exp.pm   = pm;
    e.exp.hm   = 4'(hours / 10);
    e.exp.hl   = 4'(hours % 10);
    e.exp.mm   = 4'(minutes / 10);
    e.exp.ml   = 4'(minutes % 10);
    e.exp.sm   = 4'd0;
    e.exp.sl   = 4'd0;
    e.exp.aen  = aen;
    e.exp.sact = sact;
    sb_q.push_back(e);
  endtask

  // Press the selected buttons for hold_cycles, then leave a release gap
  task automatic apply_stimulus(input logic [2:0] which, input int hold_cycles);
    if (which[0]) btn_hours = 1'b1;
    if (which[1]) btn_minutes = 1'b1;
    if (which[2]) btn_arm = 1'b1;
    repeat (hold_cycles) @(negedge clk_fast);
    btn_hours   = 1'b0;
    btn_minutes = 1'b0;
    btn_arm     = 1'b0;
    repeat (3) @(negedge clk_fast);
  endtask

  // Compare one scoreboard entry against the DUT outputs
  task automatic check_output(input entry_t e);
    snap_t act;
    act = '{alarm_pm, alarm_hours_msd, alarm_hours_lsd, alarm_minutes_msd,
            alarm_minutes_lsd, alarm_seconds_msd, alarm_seconds_lsd,
            alarm_enable, setting_active};
    vectors++;
    if (act !== e.exp) begin
      miscompares++;
      $display("[TB] FAIL %s cyc=%0d got pm=%0d %h%h:%h%h:%h%h aen=%0d sact=%0d want pm=%0d %h%h:%h%h:%h%h aen=%0d sact=%0d",
               e.name, cyc, act.pm, act.hm, act.hl, act.mm, act.ml, act.sm, act.sl,
               act.aen, act.sact, e.exp.pm, e.exp.hm, e.exp.hl, e.exp.mm, e.exp.ml,
               e.exp.sm, e.exp.sl, e.exp.aen, e.exp.sact);
    end
  endtask

  // Monitor: away from the active edge, retire every entry that is due
  always @(negedge clk_fast) begin
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      check_output(sb_q.pop_front());
    end
  end

  // Directed stimulus
  initial begin
    int h;
    int m;
    logic pm;
    int inc_edges[9] = '{3, 7, 9, 11, 13, 15, 17, 19, 21};
    entry_t left;

    reset = 1'b1;
    en = 1'b1;
    btn_hours = 1'b0;
    btn_minutes = 1'b0;
    btn_arm = 1'b0;

    // Reset state, then first cycles after release
    repeat (2) @(negedge clk_fast);
    push_expect(1, "in_reset", 1'b0, 12, 0, 1'b0, 1'b0);
    @(negedge clk_fast);
    reset = 1'b0;
    push_expect(2, "after_reset", 1'b0, 12, 0, 1'b0, 1'b0);
    repeat (3) @(negedge clk_fast);

    // Hours stepping: 12 AM -> 1..11 AM -> 12 PM -> 1..11 PM -> 12 AM -> 1 AM
    for (int i = 1; i <= 25; i++) begin
      h = i % 12;
      if (h == 0) h = 12;
      pm = (i >= 12 && i <= 23);
      if (i == 1) push_expect(2, "hours_latency", 1'b0, 12, 0, 1'b0, 1'b0);
      push_expect(3, "hours_step", pm, h, 0, 1'b0, 1'b1);
      apply_stimulus(B_HOURS, 3);
    end

    // Minutes held 20 cycles from 1:00 AM: incs on edges +3,+7, then every 2
    for (int d = 1; d <= 25; d++) begin
      m = 0;
      foreach (inc_edges[j]) if (inc_edges[j] <= d) m++;
      push_expect(d, "min_hold", 1'b0, 1, m, 1'b0, (d >= 3 && d <= 22));
    end
    apply_stimulus(B_MINUTES, 20);
    repeat (3) @(negedge clk_fast);

    // Single presses 09 -> 58
    for (int i = 1; i <= 49; i++) begin
      push_expect(3, "min_step", 1'b0, 1, 9 + i, 1'b0, 1'b1);
      apply_stimulus(B_MINUTES, 3);
    end

    // Hold from 58: 59, then 00 with no carry into hours, then stop
    push_expect(3, "min_59", 1'b0, 1, 59, 1'b0, 1'b1);
    push_expect(7, "min_wrap", 1'b0, 1, 0, 1'b0, 1'b1);
    push_expect(12, "min_wrap_hours", 1'b0, 1, 0, 1'b0, 1'b0);
    apply_stimulus(B_MINUTES, 6);
    repeat (5) @(negedge clk_fast);

    // Hours 1 AM -> 12 AM (23 presses), minutes 00 -> 59 (59 presses)
    for (int i = 1; i <= 23; i++) begin
      h = (1 + i) % 12;
      if (h == 0) h = 12;
      pm = (i >= 11 && i <= 22);
      push_expect(3, "hours_to_12am", pm, h, 0, 1'b0, 1'b1);
      apply_stimulus(B_HOURS, 3);
    end
    for (int i = 1; i <= 59; i++) begin
      push_expect(3, "min_to_59", 1'b0, 12, i, 1'b0, 1'b1);
      apply_stimulus(B_MINUTES, 3);
    end

    // Both buttons on the same edge from 12:59 AM
    push_expect(2, "both_before", 1'b0, 12, 59, 1'b0, 1'b0);
    push_expect(3, "both_same_edge", 1'b0, 1, 0, 1'b0, 1'b1);
    apply_stimulus(B_HOURS | B_MINUTES, 3);

    // Disabled: every button ignored, values held
    en = 1'b0;
    push_expect(3, "en0_arm", 1'b0, 1, 0, 1'b0, 1'b0);
    apply_stimulus(B_ARM, 3);
    push_expect(3, "en0_hours", 1'b0, 1, 0, 1'b0, 1'b1);
    apply_stimulus(B_HOURS, 3);
    push_expect(3, "en0_minutes", 1'b0, 1, 0, 1'b0, 1'b1);
    apply_stimulus(B_MINUTES, 3);

    // en rises with hours already held: no edge, no auto-repeat
    push_expect(10, "en_rise_held", 1'b0, 1, 0, 1'b0, 1'b1);
    push_expect(16, "en_rise_held_long", 1'b0, 1, 0, 1'b0, 1'b1);
    btn_hours = 1'b1;
    repeat (4) @(negedge clk_fast);
    en = 1'b1;
    repeat (12) @(negedge clk_fast);
    btn_hours = 1'b0;
    repeat (3) @(negedge clk_fast);
    push_expect(3, "en_repress", 1'b0, 2, 0, 1'b0, 1'b1);
    apply_stimulus(B_HOURS, 3);

    // Arm toggles once per press even when held 10 cycles
    push_expect(3, "arm_on", 1'b0, 2, 0, 1'b1, 1'b0);
    push_expect(12, "arm_on_no_repeat", 1'b0, 2, 0, 1'b1, 1'b0);
    apply_stimulus(B_ARM, 10);
    push_expect(3, "arm_off", 1'b0, 2, 0, 1'b0, 1'b0);
    push_expect(12, "arm_off_no_repeat", 1'b0, 2, 0, 1'b0, 1'b0);
    apply_stimulus(B_ARM, 10);
    push_expect(3, "arm_on_again", 1'b0, 2, 0, 1'b1, 1'b0);
    apply_stimulus(B_ARM, 3);
    for (int i = 1; i <= 7; i++) begin
      push_expect(3, "min_to_07", 1'b0, 2, i, 1'b1, 1'b1);
      apply_stimulus(B_MINUTES, 3);
    end

    // Reset mid-hold of minutes at 2:07 AM, armed; button held across release
    push_expect(1, "pre_reset", 1'b0, 2, 7, 1'b1, 1'b0);
    push_expect(3, "reset_mid_hold", 1'b0, 12, 0, 1'b0, 1'b0);
    push_expect(6, "reset_release", 1'b0, 12, 0, 1'b0, 1'b0);
    push_expect(7, "held_through_reset", 1'b0, 12, 1, 1'b0, 1'b1);
    push_expect(14, "held_through_reset_end", 1'b0, 12, 1, 1'b0, 1'b0);
    btn_minutes = 1'b1;
    repeat (2) @(negedge clk_fast);
    reset = 1'b1;
    repeat (2) @(negedge clk_fast);
    reset = 1'b0;
    repeat (3) @(negedge clk_fast);
    btn_minutes = 1'b0;
    repeat (9) @(negedge clk_fast);

    // Let the monitor drain; anything left is a failure
    for (int t = 0; t < 20 && sb_q.size() > 0; t++) @(negedge clk_fast);
    while (sb_q.size() > 0) begin
      left = sb_q.pop_front();
      vectors++;
      miscompares++;
      $display("[TB] FAIL %s never checked: due cyc=%0d, now cyc=%0d", left.name, left.cyc, cyc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
